// File: rtl/rdp_noc_arb.sv
// rdp_noc_arb: packet-atomic round-robin arbiter sharing the NoC dp port between NUM_REQ rdp lanes.
// Latency: 1 cycle from requester transfer to arb__noc__dp_valid (single output register).
// Backpressure: at most one ready, only when the output register is empty or draining this cycle.
// Optional: define RDP_NOC_ARB_PKT_CNT_EN to add per-requester completed-packet counters (arb__sts__pkt_cnt).
module rdp_noc_arb #(
  parameter int NUM_REQ  = 4,
  parameter int REQ_ID_W = 2,
  parameter int TYPE_W   = 2,
  parameter int PEID_W   = 6,
  parameter int LANE_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset_poweron_n,
  input  logic [NUM_REQ-1:0]       req__arb__valid,
  output logic [NUM_REQ-1:0]       arb__req__ready,
  input  logic [2*NUM_REQ-1:0]     req__arb__cntl,
  input  logic [TYPE_W*NUM_REQ-1:0] req__arb__type,
  input  logic [PEID_W*NUM_REQ-1:0] req__arb__peId,
  input  logic [LANE_W*NUM_REQ-1:0] req__arb__laneId,
  input  logic [NUM_REQ-1:0]       req__arb__strmId,
  input  logic [DATA_W*NUM_REQ-1:0] req__arb__data,
  input  logic                     noc__arb__dp_ready,
  output logic                     arb__noc__dp_valid,
  output logic [1:0]               arb__noc__dp_cntl,
  output logic [TYPE_W-1:0]        arb__noc__dp_type,
  output logic [PEID_W-1:0]        arb__noc__dp_peId,
  output logic [LANE_W-1:0]        arb__noc__dp_laneId,
  output logic                     arb__noc__dp_strmId,
  output logic [DATA_W-1:0]        arb__noc__dp_data,
  output logic [REQ_ID_W-1:0]      arb__sts__grant_id,
  output logic                     arb__sts__locked,
  output logic                     arb__sts__proto_err
`ifdef RDP_NOC_ARB_PKT_CNT_EN
  ,
  output logic [16*NUM_REQ-1:0]    arb__sts__pkt_cnt
`endif
);

  localparam logic [1:0] CNTL_MOM     = 2'b00;
  localparam logic [1:0] CNTL_SOM     = 2'b01;
  localparam logic [1:0] CNTL_EOM     = 2'b10;
  localparam logic [1:0] CNTL_SOM_EOM = 2'b11;
  localparam logic [REQ_ID_W-1:0] LAST_ID = REQ_ID_W'(NUM_REQ - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [REQ_ID_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [REQ_ID_W-1:0] r_lock_id, w_lock_id_nxt;
  logic [REQ_ID_W-1:0] r_grant_id;
  logic [REQ_ID_W-1:0] w_gnt, w_gnt_inc;
  logic                w_gnt_vld, w_space, w_xfer, w_fwd, w_err;
  logic [1:0]          w_cntl_sel;

  logic                r_dp_valid;
  logic [1:0]          r_dp_cntl;
  logic [TYPE_W-1:0]   r_dp_type;
  logic [PEID_W-1:0]   r_dp_peId;
  logic [LANE_W-1:0]   r_dp_laneId;
  logic                r_dp_strmId;
  logic [DATA_W-1:0]   r_dp_data;
  logic                r_proto_err;

  logic [1:0]          w_cntl_a [NUM_REQ];
  logic [TYPE_W-1:0]   w_type_a [NUM_REQ];
  logic [PEID_W-1:0]   w_peid_a [NUM_REQ];
  logic [LANE_W-1:0]   w_lane_a [NUM_REQ];
  logic [DATA_W-1:0]   w_data_a [NUM_REQ];

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_cntl_a[gi] = req__arb__cntl[2*gi +: 2];
    assign w_type_a[gi] = req__arb__type[TYPE_W*gi +: TYPE_W];
    assign w_peid_a[gi] = req__arb__peId[PEID_W*gi +: PEID_W];
    assign w_lane_a[gi] = req__arb__laneId[LANE_W*gi +: LANE_W];
    assign w_data_a[gi] = req__arb__data[DATA_W*gi +: DATA_W];
  end

  // Output register can take a beat when empty or when the NoC drains it this cycle.
  assign w_space    = ~r_dp_valid | noc__arb__dp_ready;
  assign w_xfer     = w_gnt_vld & w_space & reset_poweron_n;
  assign w_cntl_sel = w_cntl_a[w_gnt];
  assign w_gnt_inc  = (w_gnt == LAST_ID) ? '0 : w_gnt + 1'b1;

  // Grant select: lock owner when locked, else first valid searching upward from rr_ptr.
  always_comb begin
    int                  idx;
    logic [REQ_ID_W-1:0] sel;
    w_gnt_vld = 1'b0;
    w_gnt     = r_rr_ptr;
    idx       = 0;
    sel       = '0;
    if (r_state == ST_LOCKED) begin
      w_gnt     = r_lock_id;
      w_gnt_vld = req__arb__valid[r_lock_id];
    end else begin
      // Walk from the farthest candidate back so the nearest valid one wins.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        idx = int'(r_rr_ptr) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        sel = REQ_ID_W'(idx);
        if (req__arb__valid[sel]) begin
          w_gnt     = sel;
          w_gnt_vld = 1'b1;
        end
      end
    end
  end

  // One-hot ready to the granted requester on a transfer.
  always_comb begin
    arb__req__ready = '0;
    if (w_xfer) arb__req__ready[w_gnt] = 1'b1;
  end

  // Next-state: packet lock, priority rotation and protocol checking.
  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_lock_id_nxt = r_lock_id;
    w_fwd         = 1'b0;
    w_err         = 1'b0;
    if (w_xfer) begin
      case (r_state)
        ST_IDLE: begin
          case (w_cntl_sel)
            CNTL_SOM_EOM: begin
              w_fwd        = 1'b1;
              w_rr_ptr_nxt = w_gnt_inc;
            end
            CNTL_SOM: begin
              w_fwd         = 1'b1;
              w_state_nxt   = ST_LOCKED;
              w_lock_id_nxt = w_gnt;
            end
            // A continuation beat with no open packet is consumed and dropped.
            default: w_err = 1'b1;
          endcase
        end
        default: begin
          w_fwd = 1'b1;
          case (w_cntl_sel)
            CNTL_MOM: ;
            CNTL_EOM: begin
              w_state_nxt  = ST_IDLE;
              w_rr_ptr_nxt = w_gnt_inc;
            end
            // A new start inside an open packet is flagged but passed through.
            default: w_err = 1'b1;
          endcase
        end
      endcase
    end
  end

  // FSM state, rotation pointer and lock owner.
  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_lock_id <= w_lock_id_nxt;
    end
  end

  // Output beat register and status flags.
  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      r_dp_valid  <= 1'b0;
      r_dp_cntl   <= '0;
      r_dp_type   <= '0;
      r_dp_peId   <= '0;
      r_dp_laneId <= '0;
      r_dp_strmId <= 1'b0;
      r_dp_data   <= '0;
      r_grant_id  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_fwd) begin
        r_dp_valid  <= 1'b1;
        r_dp_cntl   <= w_cntl_sel;
        r_dp_type   <= w_type_a[w_gnt];
        r_dp_peId   <= w_peid_a[w_gnt];
        r_dp_laneId <= w_lane_a[w_gnt];
        r_dp_strmId <= req__arb__strmId[w_gnt];
        r_dp_data   <= w_data_a[w_gnt];
      end else if (noc__arb__dp_ready) begin
        r_dp_valid <= 1'b0;
      end
      if (w_xfer) r_grant_id <= w_gnt;
      if (w_err) r_proto_err <= 1'b1;
    end
  end

  assign arb__noc__dp_valid  = r_dp_valid;
  assign arb__noc__dp_cntl   = r_dp_cntl;
  assign arb__noc__dp_type   = r_dp_type;
  assign arb__noc__dp_peId   = r_dp_peId;
  assign arb__noc__dp_laneId = r_dp_laneId;
  assign arb__noc__dp_strmId = r_dp_strmId;
  assign arb__noc__dp_data   = r_dp_data;
  assign arb__sts__grant_id  = r_grant_id;
  assign arb__sts__locked    = (r_state == ST_LOCKED);
  assign arb__sts__proto_err = r_proto_err;

`ifdef RDP_NOC_ARB_PKT_CNT_EN
  logic [15:0] r_pkt_cnt [NUM_REQ];

  // Saturating per-requester count of forwarded end-of-packet beats.
  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_pkt_cnt[i] <= '0;
    end else if (w_fwd && w_cntl_sel[1] && (r_pkt_cnt[w_gnt] != 16'hFFFF)) begin
      r_pkt_cnt[w_gnt] <= r_pkt_cnt[w_gnt] + 16'd1;
    end
  end

  for (gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_out
    assign arb__sts__pkt_cnt[16*gi +: 16] = r_pkt_cnt[gi];
  end
`endif

endmodule

// File: doc/rdp_noc_arb.md
Name: rdp_noc_arb

Overview:
- Packet-atomic round-robin arbiter sharing the manager's NoC data-path (dp) interface between NUM_REQ return-data-processor lanes.
- Each requester presents a complete dp beat (cntl, type, peId, laneId, strmId, data) under valid/ready.
- Once a packet's first beat is granted, the arbiter locks to that requester until the packet's end beat, then rotates priority.
- Sits between the rdp lane instances and the NoC dp port; the output is registered.

Parameters:
- NUM_REQ, 4, number of requesting lanes (2..8).
- REQ_ID_W, 2, width of the grant index; equals clog2(NUM_REQ).
- TYPE_W, 2, NoC packet type width.
- PEID_W, 6, PE id width.
- LANE_W, 5, lane id width.
- DATA_W, 32, dp data width.

Ports:
- clk  in  1  clock.
- reset_poweron_n  in  1  synchronous reset, active-low.
- req__arb__valid  in  NUM_REQ  per-requester beat valid.
- arb__req__ready  out  NUM_REQ  per-requester beat accepted.
- req__arb__cntl  in  2*NUM_REQ  beat delineator: MOM=00, SOM=01, EOM=10, SOM_EOM=11.
- req__arb__type  in  TYPE_W*NUM_REQ  packet type.
- req__arb__peId  in  PEID_W*NUM_REQ  destination PE.
- req__arb__laneId  in  LANE_W*NUM_REQ  lane id.
- req__arb__strmId  in  NUM_REQ  stream id.
- req__arb__data  in  DATA_W*NUM_REQ  payload.
- noc__arb__dp_ready  in  1  NoC accepts the output beat.
- arb__noc__dp_valid  out  1  output beat valid.
- arb__noc__dp_cntl / _type / _peId / _laneId / _strmId / _data  out  2 / TYPE_W / PEID_W / LANE_W / 1 / DATA_W  registered beat fields.
- arb__sts__grant_id  out  REQ_ID_W  current or last granted requester.
- arb__sts__locked  out  1  packet lock held.
- arb__sts__proto_err  out  1  sticky protocol error.

Behaviour:
- Reset (reset_poweron_n low at a clk edge):
  - state=IDLE, rr_ptr=0.
  - All outputs 0, including arb__req__ready and arb__noc__dp_valid.
  - proto_err cleared.
  - Reset mid-packet: the lock and output beat are discarded, with no completion beat.
- Output stage:
  - One register; space = ~dp_valid | noc__arb__dp_ready.
  - dp_valid is cleared on a NoC accept when no new load occurs in the same cycle.
  - Latency is 1 cycle from the requester transfer to dp_valid.
- Transfer: req__arb__valid[g] & arb__req__ready[g]. At most one ready bit is high per cycle, and ready is high only when space=1.
- State IDLE:
  - The grant g is the first valid requester searching rr_ptr, rr_ptr+1, ..., wrapping NUM_REQ-1 to 0.
  - Grant is combinational, so back-to-back packets from different requesters have no bubble.
  - Transfer with cntl=SOM_EOM: forward the beat, stay IDLE, rr_ptr=(g+1) mod NUM_REQ.
  - Transfer with cntl=SOM: forward the beat, go to LOCKED with lock_id=g.
  - Transfer with cntl=MOM or EOM: set proto_err, consume and drop the beat (no NoC output), leave rr_ptr unchanged.
- State LOCKED:
  - Only lock_id is eligible; other valids are held off regardless of priority.
  - MOM: forward the beat.
  - EOM: forward the beat, go to IDLE, rr_ptr=(lock_id+1) mod NUM_REQ.
  - SOM or SOM_EOM: set proto_err, forward the beat unchanged, remain LOCKED.
- Idle input: no valid in IDLE means no state change and rr_ptr holds.
- Status outputs:
  - grant_id updates on each accepted transfer.
  - locked = (state==LOCKED).
- NoC backpressure: with noc ready low and dp_valid high, all arb__req__ready are 0 and the held output fields are stable.
- Simultaneous load and drain: when the NoC accepts and a new beat is loaded in the same cycle, dp_valid stays 1 and the new fields replace the old.

Optional Feature:
- Macro: RDP_NOC_ARB_PKT_CNT_EN.
- With the macro defined:
  - Add output arb__sts__pkt_cnt, width 16*NUM_REQ.
  - Per-requester counter increments on each forwarded EOM or SOM_EOM beat.
  - Counters saturate at 16'hFFFF and reset to 0.
- Without the macro: the port and counters are absent; everything else is identical.

Test Plan:
- Single requester 1 sends SOM_EOM data=0xA5, NoC ready=1 → dp_valid=1 one cycle later with cntl=11, data=0xA5; rr_ptr becomes 2.
- Requesters 0 and 2 both send 3-beat packets (SOM, MOM, EOM) simultaneously from reset → requester 0's three beats are contiguous on NoC, then requester 2's; grant_id sequence is 0,0,0,2,2,2; no interleave.
- Requester 3 holds the lock while requester 0 is valid; requester 3 issues EOM → next grant is 0 (wrap 3→0), zero idle cycles between packets.
- NoC ready low for 5 cycles mid-packet → dp fields stable, all arb__req__ready=0; on release the beats resume in order with none lost or duplicated.
- Requester 1 sends MOM while IDLE → beat dropped, proto_err=1 and stays set; a subsequent SOM_EOM from requester 1 is forwarded normally.
- reset_poweron_n low for one cycle while LOCKED mid-packet → next cycle all outputs are 0 and state is IDLE; with RDP_NOC_ARB_PKT_CNT_EN, counters read 0 and increment by 1 per completed packet afterward.
